// File: rtl/out_channel_checker.sv
// out_channel_checker: captures the words the program engine emits, buffers
// them in a small FIFO, forwards them on a valid/ready stream, checks each
// forwarded word against a loadable table of expected values and produces the
// run-level finished/success verdict.
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 5,
    parameter int Depth              = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          outValid,
    input  logic [MemoryElementWidth-1:0] outData,
    input  logic                          progFinished,
    input  logic                          expWrite,
    input  logic [$clog2(NOut)-1:0]       expAddr,
    input  logic [MemoryElementWidth-1:0] expData,
    output logic                          txValid,
    output logic [MemoryElementWidth-1:0] txData,
    input  logic                          txReady,
    output logic [15:0]                   count,
    output logic [15:0]                   mismatchIndex,
    output logic                          overflow,
    output logic                          finished,
    output logic                          success
);

    localparam int AW = $clog2(NOut);
    localparam int PW = $clog2(Depth) + 1;
    localparam int IW = PW - 1;
    localparam int W  = MemoryElementWidth;

    localparam logic [AW:0] NOUT_A  = (AW+1)'(NOut);
    localparam logic [15:0] NOUT_16 = 16'(NOut);
    localparam logic [15:0] NO_MISMATCH = 16'hFFFF;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [W-1:0]  exp_mem  [NOut];
    logic [W-1:0]  fifo_mem [Depth];

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   mismatch_q, mismatch_d;
    logic          overflow_q, overflow_d;
    logic          success_q, success_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          push;
    logic          pop;
    logic [W-1:0]  head_word;
    logic [W-1:0]  exp_word;
    logic          word_bad;

    // FIFO status from the pointers: equal means empty, MSB-only difference means full
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
        head_word  = fifo_mem[rd_ptr_q[IW-1:0]];
        pop        = !fifo_empty && txReady;
        push_req   = outValid && (state_q == ST_RUN);
        push       = push_req && (!fifo_full || pop);
    end

    // Look up the expected value for the word being popped; past the table end every word is bad
    always_comb begin
        exp_word = '0;
        word_bad = 1'b1;
        if (count_q < NOUT_16) begin
            exp_word = exp_mem[count_q[AW-1:0]];
            word_bad = (head_word != exp_word);
        end
    end

    // Next-state logic for the FIFO pointers, check counters, error flags and verdict FSM
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        overflow_d = overflow_q;
        success_d  = success_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (push_req && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (outValid && (state_q == ST_DRAIN)) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (word_bad && (mismatch_q == NO_MISMATCH)) begin
                mismatch_d = count_q;
            end
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (progFinished) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !push && !pop) begin
                    state_d   = ST_DONE;
                    success_d = !overflow_d && (mismatch_d == NO_MISMATCH) &&
                                (count_d == NOUT_16);
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // Register all control state; a low reset returns everything except the tables to idle
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mismatch_q <= NO_MISMATCH;
            overflow_q <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            overflow_q <= overflow_d;
            success_q  <= success_d;
        end
    end

    // FIFO storage write; a push that coincides with reset is discarded
    always_ff @(posedge clock) begin
        if (reset && push) begin
            fifo_mem[wr_ptr_q[IW-1:0]] <= outData;
        end
    end

    // Expected table is loadable at any time, reset included, and is never cleared
    always_ff @(posedge clock) begin
        if (expWrite && ({1'b0, expAddr} < NOUT_A)) begin
            exp_mem[expAddr] <= expData;
        end
    end

    assign txValid       = !fifo_empty;
    assign txData        = fifo_empty ? '0 : head_word;
    assign count         = count_q;
    assign mismatchIndex = mismatch_q;
    assign overflow      = overflow_q;
    assign finished      = (state_q == ST_DONE);
    assign success       = success_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// tb_out_channel_checker: table-driven vectors for the nominal run plus
// hand-written sequences for mismatch, overflow, full-with-pop, short/long
// runs, late writes during drain and reset in the middle of a drain.
module tb_out_channel_checker;

    localparam int W = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          outValid = 1'b0;
    logic [W-1:0]  outData = '0;
    logic          progFinished = 1'b0;
    logic          expWrite = 1'b0;
    logic [2:0]    expAddr = '0;
    logic [W-1:0]  expData = '0;
    logic          txValid;
    logic [W-1:0]  txData;
    logic          txReady = 1'b0;
    logic [15:0]   count;
    logic [15:0]   mismatchIndex;
    logic          overflow;
    logic          finished;
    logic          success;

    int num_checks   = 0;
    int num_failures = 0;

    typedef struct {
        logic          out_valid;
        logic [W-1:0]  out_data;
        logic          prog_finished;
        logic          tx_ready;
        logic          exp_valid;
        logic [W-1:0]  exp_data;
        logic [15:0]   exp_count;
        logic [15:0]   exp_mismatch;
        logic          exp_overflow;
        logic          exp_finished;
        logic          exp_success;
    } vec_t;

    vec_t vecs [15];

    out_channel_checker #(
        .MemoryElementWidth(W),
        .NOut(5),
        .Depth(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .outValid(outValid),
        .outData(outData),
        .progFinished(progFinished),
        .expWrite(expWrite),
        .expAddr(expAddr),
        .expData(expData),
        .txValid(txValid),
        .txData(txData),
        .txReady(txReady),
        .count(count),
        .mismatchIndex(mismatchIndex),
        .overflow(overflow),
        .finished(finished),
        .success(success)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Advance one cycle and settle just after the active edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic ov, input logic [W-1:0] od,
                                 input logic pf, input logic rdy);
        outValid     = ov;
        outData      = od;
        progFinished = pf;
        txReady      = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " txValid"}, 32'(txValid), 32'd0);
        checkOutput({tag, " txData"}, 32'(txData), 32'd0);
        checkOutput({tag, " count"}, 32'(count), 32'd0);
        checkOutput({tag, " mismatchIndex"}, 32'(mismatchIndex), 32'hFFFF);
        checkOutput({tag, " overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, " finished"}, 32'(finished), 32'd0);
        checkOutput({tag, " success"}, 32'(success), 32'd0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Wait a bounded number of cycles for the verdict
    task automatic waitFinished(input string tag, input int budget);
        int n = 0;
        while (!finished && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, " finished"}, 32'(finished), 32'd1);
    endtask

    // Push words with one idle cycle between them, consumer always ready, then finish
    task automatic runSequence(input string tag, input logic [W-1:0] words [8], input int n,
                               input logic [15:0] exp_count, input logic [15:0] exp_mm,
                               input logic exp_succ);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, words[i], 1'b0, 1'b1);
            tick();
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        waitFinished(tag, 10);
        checkOutput({tag, " count"}, 32'(count), 32'(exp_count));
        checkOutput({tag, " mismatchIndex"}, 32'(mismatchIndex), 32'(exp_mm));
        checkOutput({tag, " success"}, 32'(success), 32'(exp_succ));
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] words [8];
        logic [W-1:0] table_vals [5];

        // Nominal run: each vector is applied for one cycle, outputs checked after the edge
        vecs[0]  = '{1'b1, 12'd1, 1'b0, 1'b1, 1'b1, 12'd1, 16'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 12'd0, 16'd1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 12'd2, 1'b0, 1'b1, 1'b1, 12'd2, 16'd1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 12'd0, 16'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 12'd1, 1'b0, 1'b1, 1'b1, 12'd1, 16'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 12'd0, 16'd3, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 12'd1, 1'b0, 1'b1, 1'b1, 12'd1, 16'd3, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 12'd0, 16'd4, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 12'd2, 1'b0, 1'b1, 1'b1, 12'd2, 16'd4, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 12'd0, 16'd5, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 12'd0, 16'd5, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 12'd0, 1'b1, 1'b1, 1'b0, 12'd0, 16'd5, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 12'd0, 1'b1, 1'b1, 1'b0, 12'd0, 16'd5, 16'hFFFF, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 12'd0, 16'd5, 16'hFFFF, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 12'd9, 1'b0, 1'b1, 1'b0, 12'd0, 16'd5, 16'hFFFF, 1'b0, 1'b1, 1'b1};

        table_vals[0] = 12'd1;
        table_vals[1] = 12'd2;
        table_vals[2] = 12'd1;
        table_vals[3] = 12'd1;
        table_vals[4] = 12'd2;

        $display("[TB] Loading expected table while reset is held low");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expWrite = 1'b1;
            expAddr  = 3'(i);
            expData  = table_vals[i];
            tick();
        end
        expWrite = 1'b0;
        checkResetValues("reset");
        reset = 1'b1;

        $display("[TB] Nominal table-driven run");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].out_valid, vecs[i].out_data, vecs[i].prog_finished,
                          vecs[i].tx_ready);
            tick();
            checkOutput($sformatf("vec%0d txValid", i), 32'(txValid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d txData", i), 32'(txData), 32'(vecs[i].exp_data));
            end
            checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d mismatchIndex", i), 32'(mismatchIndex),
                        32'(vecs[i].exp_mismatch));
            checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_overflow));
            checkOutput($sformatf("vec%0d finished", i), 32'(finished), 32'(vecs[i].exp_finished));
            checkOutput($sformatf("vec%0d success", i), 32'(success), 32'(vecs[i].exp_success));
        end

        $display("[TB] Mismatch run");
        doReset();
        words = '{12'd1, 12'd2, 12'd7, 12'd1, 12'd2, 12'd0, 12'd0, 12'd0};
        runSequence("mismatch", words, 5, 16'd5, 16'd2, 1'b0);

        $display("[TB] Short run");
        doReset();
        words = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0};
        runSequence("short", words, 4, 16'd4, 16'hFFFF, 1'b0);

        $display("[TB] Long run");
        doReset();
        words = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2, 12'd3, 12'd0, 12'd0};
        runSequence("long", words, 6, 16'd6, 16'd5, 1'b0);

        $display("[TB] Overflow with consumer stalled");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 12'(10 + i), 1'b0, 1'b0);
            tick();
            if (i == 3) checkOutput("ovf after 4 pushes", 32'(overflow), 32'd0);
        end
        checkOutput("ovf after 5 pushes", 32'(overflow), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovf retained%0d valid", i), 32'(txValid), 32'd1);
            checkOutput($sformatf("ovf retained%0d data", i), 32'(txData), 32'(10 + i));
            tick();
        end
        checkOutput("ovf drained", 32'(txValid), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        waitFinished("ovf", 10);
        checkOutput("ovf success", 32'(success), 32'd0);

        $display("[TB] Full FIFO with simultaneous push and pop");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 12'(20 + i), 1'b0, 1'b0);
            tick();
        end
        checkOutput("full head", 32'(txData), 32'd20);
        applyStimulus(1'b1, 12'd24, 1'b0, 1'b1);
        tick();
        checkOutput("full+pop overflow", 32'(overflow), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("full+pop order%0d", i), 32'(txData), 32'(21 + i));
            tick();
        end
        checkOutput("full+pop empty", 32'(txValid), 32'd0);

        $display("[TB] Late write during drain");
        doReset();
        words = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, words[i], 1'b0, 1'b1);
            tick();
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 12'd2, 1'b1, 1'b0);
        tick();
        checkOutput("drain push accepted", 32'(txData), 32'd2);
        applyStimulus(1'b1, 12'd5, 1'b1, 1'b0);
        tick();
        checkOutput("drain late overflow", 32'(overflow), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        waitFinished("drain", 10);
        checkOutput("drain count", 32'(count), 32'd5);
        checkOutput("drain mismatchIndex", 32'(mismatchIndex), 32'hFFFF);
        checkOutput("drain success", 32'(success), 32'd0);

        $display("[TB] Reset in the middle of a drain");
        doReset();
        applyStimulus(1'b1, 12'd1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 12'd2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("middrain queued", 32'(txValid), 32'd1);
        applyStimulus(1'b1, 12'd3, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        checkResetValues("middrain");
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("middrain stays empty", 32'(txValid), 32'd0);
        words = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2, 12'd0, 12'd0, 12'd0};
        runSequence("rerun", words, 5, 16'd5, 16'hFFFF, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_failures);
        $finish;
    end

endmodule
